icache_resp: RTL

- Instruction-side responder to the fetch stage: samples the fetch PC, returns the 32-bit instruction word with a one-cycle valid pulse.
- Direct-mapped, one word per line; hits served from an internal array.
- Misses go to the memory controller through a req/done handshake, then fill the line.
- Sits between IF (upstream) and the memory controller (downstream).

---
 rtl/icache_resp_pkg.sv | 14 +
 rtl/icache_array.sv | 46 ++++
 rtl/icache_resp.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/icache_resp_pkg.sv
// Shared definitions for the instruction-cache responder: FSM state encodings,
// default geometry and the common zero constant used for reset values.
package icache_resp_pkg;

    localparam int DEFAULT_INDEX_BITS = 6;
    localparam logic [31:0] null32 = 32'h0000_0000;

    typedef enum logic [1:0] {
        ICACHE_IDLE = 2'b00,
        ICACHE_MISS = 2'b01,
        ICACHE_DROP = 2'b10
    } icache_state_e;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped line storage: valid/tag/data per line, combinational read port,
// single write port. Only the valid bits are cleared by reset.
module icache_array #(
    parameter int INDEX_BITS = 6,
    parameter int XLEN       = 32,
    parameter int TAG_W      = XLEN - INDEX_BITS - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [XLEN-1:0]       rd_data,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [XLEN-1:0]       wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [XLEN-1:0]  data_q [LINES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag/data carry no reset; a line is meaningless until its valid bit is set.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache_resp.sv
// Instruction-side responder: hit/miss lookup, memory req/done handshake and
// flush handling. Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_resp
    import icache_resp_pkg::*;
#(
    parameter int INDEX_BITS = DEFAULT_INDEX_BITS,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic [XLEN-1:0] pc_in,
    input  logic            is_stall,
    input  logic            jp_wrong,
    output logic            ins_flag,
    output logic [XLEN-1:0] ins,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_done,
`ifdef ICACHE_STATS_EN
    input  logic [XLEN-1:0] mem_data,
    output logic [31:0]     hit_cnt,
    output logic [31:0]     miss_cnt
`else
    input  logic [XLEN-1:0] mem_data
`endif
);

    localparam int TAG_W = XLEN - INDEX_BITS - 2;

    icache_state_e         state_q, state_d;
    logic                  ins_flag_q, ins_flag_d;
    logic [XLEN-1:0]       ins_q, ins_d;
    logic                  mem_req_q, mem_req_d;
    logic [XLEN-1:0]       mem_addr_q, mem_addr_d;
    logic [INDEX_BITS-1:0] miss_idx_q, miss_idx_d;
    logic [TAG_W-1:0]      miss_tag_q, miss_tag_d;

    logic [INDEX_BITS-1:0] pc_idx;
    logic [TAG_W-1:0]      pc_tag;
    logic [XLEN-1:0]       pc_aligned;
    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic [XLEN-1:0]       rd_data;
    logic                  hit;
    logic                  fill_we;
    logic                  sample;

    assign pc_idx     = pc_in[INDEX_BITS+1:2];
    assign pc_tag     = pc_in[XLEN-1:INDEX_BITS+2];
    assign pc_aligned = pc_in & ~(XLEN'(3));
    assign hit        = rd_valid && (rd_tag == pc_tag);
    assign sample     = rdy && (state_q == ICACHE_IDLE) && !ins_flag_q && !is_stall && !jp_wrong;

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .XLEN       (XLEN),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pc_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .we       (fill_we),
        .wr_idx   (miss_idx_q),
        .wr_tag   (miss_tag_q),
        .wr_data  (mem_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ICACHE_IDLE;
            ins_flag_q <= 1'b0;
            ins_q      <= XLEN'(null32);
            mem_req_q  <= 1'b0;
            mem_addr_q <= XLEN'(null32);
            miss_idx_q <= '0;
            miss_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            ins_flag_q <= ins_flag_d;
            ins_q      <= ins_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            miss_idx_q <= miss_idx_d;
            miss_tag_q <= miss_tag_d;
        end
    end

    // With rdy low every *_d equals its *_q, so the whole block freezes.
    always_comb begin
        state_d    = state_q;
        ins_flag_d = ins_flag_q;
        ins_d      = ins_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        miss_idx_d = miss_idx_q;
        miss_tag_d = miss_tag_q;
        fill_we    = 1'b0;
        if (rdy) begin
            ins_flag_d = 1'b0;
            unique case (state_q)
                ICACHE_IDLE: begin
                    if (sample) begin
                        if (hit) begin
                            ins_flag_d = 1'b1;
                            ins_d      = rd_data;
                        end else begin
                            state_d    = ICACHE_MISS;
                            mem_req_d  = 1'b1;
                            mem_addr_d = pc_aligned;
                            miss_idx_d = pc_idx;
                            miss_tag_d = pc_tag;
                        end
                    end
                end
                ICACHE_MISS: begin
                    if (mem_done) begin
                        fill_we   = 1'b1;
                        mem_req_d = 1'b0;
                        state_d   = ICACHE_IDLE;
                        if (!jp_wrong) begin
                            ins_flag_d = 1'b1;
                            ins_d      = mem_data;
                        end
                    end else if (jp_wrong) begin
                        state_d = ICACHE_DROP;
                    end
                end
                ICACHE_DROP: begin
                    if (mem_done) begin
                        fill_we   = 1'b1;
                        mem_req_d = 1'b0;
                        state_d   = ICACHE_IDLE;
                    end
                end
                default: begin
                    state_d   = ICACHE_IDLE;
                    mem_req_d = 1'b0;
                end
            endcase
        end
    end

    assign ins_flag = ins_flag_q;
    assign ins      = ins_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= null32;
            miss_cnt_q <= null32;
        end else begin
            if (sample && hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (sample && !hit) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule
